// File: rtl/mono_mode_if.sv
// Request/status bundle between the keyboard/IO side and mono_mode_ctrl.
interface mono_mode_if;
  logic [7:0] kb_code;
  logic       kb_valid;
  logic       io_wr;
  logic [1:0] io_data;
  logic       vsync;
  logic [1:0] mode;
  logic       pending;
  logic       led;

  modport master (
    output kb_code, kb_valid, io_wr, io_data, vsync,
    input  mode, pending, led
  );

  modport slave (
    input  kb_code, kb_valid, io_wr, io_data, vsync,
    output mode, pending, led
  );
endinterface

// File: rtl/mono_mode_ctrl.sv
// Colour/monochrome mode sequencer: hotkey or CPU requests, committed at vsync start or on timeout.
// Optional LED blink-out of the committed mode with macro MONO_LED_BLINK_EN.
module mono_mode_ctrl #(
  parameter logic [7:0]  HOTKEY_CODE  = 8'h7E,
  parameter logic [1:0]  RESET_MODE   = 2'b00,
  parameter logic        VS_ACTIVE    = 1'b0,
  parameter int unsigned TIMEOUT      = 1000000,
  parameter int unsigned BLINK_CYCLES = 2857142
) (
  input logic       clk_vga,
  input logic       rst_n,
  mono_mode_if.slave bus
);

  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mono_mode_ctrl: TIMEOUT must be non-zero");
  end
  if (BLINK_CYCLES == 0) begin : g_bad_blink
    $error("mono_mode_ctrl: BLINK_CYCLES must be non-zero");
  end

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXTBRK} parse_e;

  parse_e         parse_q;
  logic           held_q;
  logic [1:0]     mode_q;
  logic [1:0]     target_q;
  logic           pending_q;
  logic [TW-1:0]  tcnt_q;
  logic           vs_q;
  logic           led_q;

  logic           press;
  logic           req;
  logic           vs_edge;
  logic           commit;
  logic [1:0]     base;
  logic [1:0]     mode_d;

  // Request/commit decode; a request in the commit cycle defers the commit
  always_comb begin
    press   = 1'b0;
    if (bus.kb_valid && (parse_q == P_IDLE) && (bus.kb_code == HOTKEY_CODE) && !held_q)
      press = 1'b1;
    req     = bus.io_wr || press;
    vs_edge = (bus.vsync == VS_ACTIVE) && (vs_q != VS_ACTIVE);
    commit  = pending_q && !req && (vs_edge || (tcnt_q == TW'(TIMEOUT - 1)));
    base    = pending_q ? target_q : mode_q;
    mode_d  = commit ? target_q : mode_q;
  end

  // Set-2 scancode parser; held suppresses typematic repeats until the break code
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      parse_q <= P_IDLE;
      held_q  <= 1'b0;
    end else if (bus.kb_valid) begin
      case (parse_q)
        P_IDLE: begin
          if (bus.kb_code == CODE_EXT)         parse_q <= P_EXT;
          else if (bus.kb_code == CODE_BRK)    parse_q <= P_BRK;
          else if (bus.kb_code == HOTKEY_CODE) held_q  <= 1'b1;
        end
        P_EXT:   parse_q <= (bus.kb_code == CODE_BRK) ? P_EXTBRK : P_IDLE;
        P_BRK: begin
          if (bus.kb_code == HOTKEY_CODE) held_q <= 1'b0;
          parse_q <= P_IDLE;
        end
        default: parse_q <= P_IDLE;
      endcase
    end
  end

  // Request capture, vsync edge sampling and commit with timeout fallback
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= RESET_MODE;
      target_q  <= RESET_MODE;
      pending_q <= 1'b0;
      tcnt_q    <= '0;
      vs_q      <= ~VS_ACTIVE;
    end else begin
      vs_q <= bus.vsync;
      if (bus.io_wr) begin
        target_q  <= bus.io_data;
        pending_q <= 1'b1;
        tcnt_q    <= '0;
      end else if (press) begin
        target_q  <= base + 2'd1;
        pending_q <= 1'b1;
        tcnt_q    <= '0;
      end else if (commit) begin
        mode_q    <= target_q;
        pending_q <= 1'b0;
        tcnt_q    <= '0;
      end else if (pending_q) begin
        tcnt_q    <= tcnt_q + TW'(1);
      end else begin
        tcnt_q    <= '0;
      end
    end
  end

`ifdef MONO_LED_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [1:0] {B_IDLE, B_ON, B_OFF} blink_e;

  blink_e         blink_q;
  logic [2:0]     pulses_q;
  logic [BW-1:0]  bcnt_q;

  // Blink mode+1 pulses after each commit; a new commit restarts the sequence
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      blink_q  <= B_IDLE;
      pulses_q <= '0;
      bcnt_q   <= '0;
      led_q    <= 1'b0;
    end else if (commit) begin
      blink_q  <= B_ON;
      pulses_q <= {1'b0, mode_d} + 3'd1;
      bcnt_q   <= '0;
      led_q    <= 1'b1;
    end else begin
      case (blink_q)
        B_ON: begin
          if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_q <= B_OFF;
            bcnt_q  <= '0;
            led_q   <= 1'b0;
          end else begin
            bcnt_q  <= bcnt_q + BW'(1);
          end
        end
        B_OFF: begin
          if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
            bcnt_q <= '0;
            if (pulses_q <= 3'd1) begin
              blink_q <= B_IDLE;
            end else begin
              pulses_q <= pulses_q - 3'd1;
              blink_q  <= B_ON;
              led_q    <= 1'b1;
            end
          end else begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        default: begin
          bcnt_q <= '0;
          led_q  <= 1'b0;
        end
      endcase
    end
  end
`else
  // LED lit for any monochrome mode, tracking the mode register
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) led_q <= 1'b0;
    else        led_q <= (mode_d != 2'b00);
  end
`endif

  assign bus.mode    = mode_q;
  assign bus.pending = pending_q;
  assign bus.led     = led_q;

endmodule
